// File: rtl/morse_round_ctrl.sv
// morse_round_ctrl: Morse trainer game-round sequencer (arm, answer timeout, result hold, score).
module morse_round_ctrl #(
  parameter int NUM_ROUNDS    = 10,
  parameter int ROUND_TIMEOUT = 500,
  parameter int RESULT_HOLD   = 100,
  parameter int TMR_W         = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_i,
  input  logic       ready_i,
  input  logic       res_valid_i,
  input  logic       res_correct_i,
  output logic       start_o,
  output logic [3:0] round_o,
  output logic [3:0] score_o,
  output logic       led_ok_o,
  output logic       led_fail_o,
  output logic       busy_o,
  output logic       done_o
);
  typedef enum logic [2:0] {IDLE, ARM, ROUND, SHOW, DONE} state_t;
  state_t state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [3:0] round_n, score_n;
  logic ok_n, fail_n, btn_q, btn_rise;
  assign btn_rise = btn_i & ~btn_q;
  assign start_o  = (state == ARM) || (state == ROUND);
  assign busy_o   = (state != IDLE) && (state != DONE);
  assign done_o   = state == DONE;
  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    round_n = round_o;
    score_n = score_o;
    ok_n    = led_ok_o;
    fail_n  = led_fail_o;
    case (state)
      IDLE, DONE: if (btn_rise) begin
        state_n = ARM;
        round_n = 4'd1;
        score_n = 4'd0;
        ok_n    = 1'b0;
        fail_n  = 1'b0;
      end
      ARM: if (ready_i && !btn_rise) begin
        state_n = ROUND;
        timer_n = '0;
      end
      ROUND: if (res_valid_i) begin
        state_n = SHOW;
        timer_n = '0;
        ok_n    = res_correct_i;
        fail_n  = ~res_correct_i;
        score_n = score_o + {3'b000, res_correct_i};
      end else if (timer == TMR_W'(ROUND_TIMEOUT - 1)) begin
        state_n = SHOW;
        timer_n = '0;
        ok_n    = 1'b0;
        fail_n  = 1'b1;
      end
      SHOW: if (timer == TMR_W'(RESULT_HOLD - 1)) begin
        state_n = (round_o == 4'(NUM_ROUNDS)) ? DONE : ARM;
        round_n = (round_o == 4'(NUM_ROUNDS)) ? round_o : round_o + 4'd1;
        ok_n    = (round_o == 4'(NUM_ROUNDS)) ? led_ok_o : 1'b0;
        fail_n  = (round_o == 4'(NUM_ROUNDS)) ? led_fail_o : 1'b0;
      end
      default: state_n = IDLE;
    endcase
    // cancel overrides any verdict arriving in the same cycle
    if (btn_rise && (state == ARM || state == ROUND || state == SHOW)) begin
      state_n = IDLE;
      round_n = 4'd0;
      score_n = 4'd0;
      ok_n    = 1'b0;
      fail_n  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      btn_q      <= 1'b0;
      round_o    <= 4'd0;
      score_o    <= 4'd0;
      led_ok_o   <= 1'b0;
      led_fail_o <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      btn_q      <= btn_i;
      round_o    <= round_n;
      score_o    <= score_n;
      led_ok_o   <= ok_n;
      led_fail_o <= fail_n;
    end
  end
endmodule

// File: tb/tb_morse_round_ctrl.sv
// tb_morse_round_ctrl: cycle-accurate vector and scoreboard bench for morse_round_ctrl.
module tb_morse_round_ctrl;
  localparam int NR = 3, TO = 8, HOLD = 4;
  logic clk = 1'b0, rst = 1'b1, btn = 1'b0, ready = 1'b0, res_valid = 1'b0, res_correct = 1'b0;
  logic start, led_ok, led_fail, busy, done;
  logic [3:0] round, score;
  int n_cmp = 0, n_bad = 0;
  logic [12:0] exp_q [$];
  string name_q [$];
  typedef struct {
    logic rst, btn, ready, rv, rc;
    logic [12:0] e;
  } vec_t;
  vec_t tab [9];
  morse_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_TIMEOUT(TO), .RESULT_HOLD(HOLD), .TMR_W(4)) dut (
    .clk(clk), .rst(rst), .btn_i(btn), .ready_i(ready), .res_valid_i(res_valid),
    .res_correct_i(res_correct), .start_o(start), .round_o(round), .score_o(score),
    .led_ok_o(led_ok), .led_fail_o(led_fail), .busy_o(busy), .done_o(done)
  );
  always #5 clk = ~clk;
  function automatic logic [12:0] o(input logic st, input logic [3:0] rd, input logic [3:0] sc,
                                    input logic ok, input logic fl, input logic bz, input logic dn);
    return {st, rd, sc, ok, fl, bz, dn};
  endfunction
  task automatic step(input logic r, input logic b, input logic rdy, input logic rv, input logic rc,
                      input logic [12:0] e, input string nm);
    logic [12:0] act, want;
    string n;
    rst = r; btn = b; ready = rdy; res_valid = rv; res_correct = rc;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    n = name_q.pop_front();
    act = {start, round, score, led_ok, led_fail, busy, done};
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got start/round/score/ok/fail/busy/done=%b want %b", n, act, want);
    end
  endtask
  initial begin
    tab = '{
      '{0, 1, 0, 0, 0, o(1, 1, 0, 0, 0, 1, 0)},
      '{0, 1, 1, 0, 0, o(1, 1, 0, 0, 0, 1, 0)},
      '{0, 1, 0, 0, 0, o(1, 1, 0, 0, 0, 1, 0)},
      '{0, 1, 0, 0, 0, o(1, 1, 0, 0, 0, 1, 0)},
      '{0, 1, 0, 1, 1, o(0, 1, 1, 1, 0, 1, 0)},
      '{0, 1, 0, 0, 0, o(0, 1, 1, 1, 0, 1, 0)},
      '{0, 1, 0, 0, 0, o(0, 1, 1, 1, 0, 1, 0)},
      '{0, 1, 0, 0, 0, o(0, 1, 1, 1, 0, 1, 0)},
      '{0, 1, 0, 0, 0, o(1, 2, 1, 0, 0, 1, 0)}
    };
    step(1, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0), "reset_a");
    step(1, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0), "reset_b");
    step(0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0), "idle");
    for (int i = 0; i < 9; i++)
      step(tab[i].rst, tab[i].btn, tab[i].ready, tab[i].rv, tab[i].rc, tab[i].e, $sformatf("pass_row%0d", i));
    step(0, 0, 0, 1, 1, o(1, 2, 1, 0, 0, 1, 0), "arm_ignores_res");
    step(0, 0, 1, 0, 0, o(1, 2, 1, 0, 0, 1, 0), "to_enter");
    for (int i = 1; i < TO; i++) step(0, 0, 0, 0, 0, o(1, 2, 1, 0, 0, 1, 0), "to_wait");
    step(0, 0, 0, 0, 0, o(0, 2, 1, 0, 1, 1, 0), "to_fire");
    for (int i = 1; i < HOLD; i++) step(0, 0, 0, 0, 0, o(0, 2, 1, 0, 1, 1, 0), "to_hold");
    step(0, 0, 0, 0, 0, o(1, 3, 1, 0, 0, 1, 0), "to_next");
    step(0, 0, 1, 0, 0, o(1, 3, 1, 0, 0, 1, 0), "sim_enter");
    for (int i = 1; i < TO; i++) step(0, 0, 0, 0, 0, o(1, 3, 1, 0, 0, 1, 0), "sim_wait");
    step(0, 0, 0, 1, 1, o(0, 3, 2, 1, 0, 1, 0), "sim_fire");
    for (int i = 1; i < HOLD; i++) step(0, 0, 0, 0, 0, o(0, 3, 2, 1, 0, 1, 0), "sim_hold");
    step(0, 0, 0, 0, 0, o(0, 3, 2, 1, 0, 0, 1), "done");
    step(0, 0, 0, 0, 0, o(0, 3, 2, 1, 0, 0, 1), "done_hold");
    step(0, 1, 0, 0, 0, o(1, 1, 0, 0, 0, 1, 0), "restart");
    step(0, 0, 1, 0, 0, o(1, 1, 0, 0, 0, 1, 0), "cancel_round");
    step(0, 1, 0, 1, 1, o(0, 0, 0, 0, 0, 0, 0), "cancel");
    step(0, 1, 0, 1, 1, o(0, 0, 0, 0, 0, 0, 0), "held_no_restart_a");
    step(0, 1, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0), "held_no_restart_b");
    step(0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0), "release");
    step(0, 1, 0, 0, 0, o(1, 1, 0, 0, 0, 1, 0), "rst_arm");
    step(0, 0, 1, 0, 0, o(1, 1, 0, 0, 0, 1, 0), "rst_round");
    step(0, 0, 0, 0, 0, o(1, 1, 0, 0, 0, 1, 0), "rst_round_t1");
    step(1, 0, 0, 1, 1, o(0, 0, 0, 0, 0, 0, 0), "rst_mid_a");
    step(1, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0), "rst_mid_b");
    step(0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0), "after_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/morse_round_ctrl.md
Name: morse_round_ctrl

Overview:
- Game-round sequencer for the Morse trainer.
- Drives the level `start` into the letter display and Morse checker, and waits for the display to report ready.
- Collects one pass/fail result per round and enforces a per-round answer timeout.
- Keeps the round number and score across a fixed-length game, and sits between the user button and the trainer top level.

Parameters:
- NUM_ROUNDS, 10, rounds per game; legal range 1..15.
- ROUND_TIMEOUT, 500, cycles allowed in ROUND before the round counts as failed (5 s at 100 Hz).
- RESULT_HOLD, 100, cycles the pass/fail LEDs are held with start_o low; minimum 2.
- TMR_W, 10, timer width; must hold max(ROUND_TIMEOUT, RESULT_HOLD).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- btn_i  input  1  user start/cancel button, level, already debounced.
- ready_i  input  1  display has latched a new letter.
- res_valid_i  input  1  one-cycle pulse: checker finished judging the current round.
- res_correct_i  input  1  checker verdict, sampled only with res_valid_i.
- start_o  output  1  level to display and checker; high while a round is armed or active.
- round_o  output  4  current round, 1-based; 0 when idle.
- score_o  output  4  correct answers this game.
- led_ok_o  output  1  last round passed.
- led_fail_o  output  1  last round failed or timed out.
- busy_o  output  1  state is not IDLE and not DONE.
- done_o  output  1  game complete; final score valid.

Behaviour:
- All state and outputs are registered and update on posedge clk.
- rst has priority over everything. On rst:
  - state=IDLE, timer=0, btn_q=0;
  - all outputs 0.
- Edge detect: btn_rise = btn_i & ~btn_q, with btn_q <= btn_i every cycle.
- IDLE:
  - outputs are 0;
  - on btn_rise go to ARM with round_o=1, score_o=0, LEDs cleared.
- ARM:
  - start_o=1;
  - on ready_i go to ROUND and set timer=0;
  - there is no timeout in ARM;
  - btn_rise cancels the game (see below).
- ROUND:
  - start_o=1 and timer increments each cycle;
  - on res_valid_i go to SHOW, set led_ok_o=res_correct_i and led_fail_o=~res_correct_i, and add 1 to score_o if correct;
  - otherwise, when timer==ROUND_TIMEOUT-1, go to SHOW with led_fail_o=1 and score unchanged;
  - the timeout therefore fires after exactly ROUND_TIMEOUT cycles spent in ROUND;
  - if res_valid_i and the timeout occur in the same cycle, res_valid_i wins;
  - res_valid_i outside ROUND is ignored.
- SHOW:
  - start_o=0, which guarantees the checker returns to its idle state; timer restarts at 0;
  - after RESULT_HOLD cycles:
    - if round_o==NUM_ROUNDS, go to DONE;
    - else increment round_o, clear both LEDs and go to ARM.
- DONE:
  - done_o=1, start_o=0;
  - round_o, score_o and LEDs hold;
  - btn_rise starts a new game, identical to the IDLE-to-ARM transition.
- Cancel: btn_rise in ARM, ROUND or SHOW goes to IDLE and clears round_o, score_o and the LEDs next cycle; this takes priority over res_valid_i in the same cycle.
- A held button produces a single btn_rise only.
- busy_o and done_o are mutually exclusive.
- score_o never exceeds round_o, so no saturation is needed.
- Reset in any state returns to IDLE next cycle with start_o=0; no partial score is retained.

Test Plan (NUM_ROUNDS=3, ROUND_TIMEOUT=8, RESULT_HOLD=4):
- Reset: hold rst 2 cycles mid-ROUND -> state IDLE, start_o=0, round_o=0, score_o=0, LEDs 0.
- Pass round: btn rise, ready_i next cycle, res_valid_i=1 with res_correct_i=1 three cycles later -> led_ok_o=1, score_o=1, start_o low 4 cycles, then round_o=2 and start_o=1.
- Timeout: in ROUND, no res_valid_i -> exactly 8 cycles after entry start_o=0, led_fail_o=1, score_o unchanged.
- Simultaneous: res_valid_i with res_correct_i=1 on timeout cycle 7 -> treated as pass, score increments.
- Full game of pass/fail/pass -> done_o=1, round_o=3, score_o=2, busy_o=0; a new btn rise -> round_o=1, score_o=0, start_o=1.
- Cancel: btn rise during ROUND coinciding with res_valid_i -> IDLE next cycle, score_o=0, no LED set; a held btn_i does not restart the game.
